// File: rtl/alu_result_stage.sv
// alu_result_fifo: in-order entry queue for the ALU writeback stage.
// Latency: an entry written at one edge is visible at head after that edge.
// Backpressure: the caller must not push when full or pop when empty. The FIFO does not guard either case.
//
// Ports:
//   clock, clear        : clock and asynchronous active-low reset
//   push, push_data     : write push_data at the tail this edge
//   pop                 : retire the head entry this edge
//   head                : current head entry (don't-care when count == 0)
//   count               : current occupancy, 0..DEPTH
module alu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 69
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage has no reset. Stale contents are never visible because
    // count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow gives the
    // DEPTH-1 -> 0 wrap.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// alu_result_stage: buffered writeback stage behind the ALU. It applies HI/LO updates and passes other results to the register file.
// Latency: 2 edges from an accepted result to wb_valid. One edge enqueues and the next edge retires. Throughput is 1 per cycle.
// Backpressure: res_ready is low when the FIFO is full. A full FIFO refuses a push even when it pops in the same cycle. wb output holds while wb_ready is low.
//
// Ports:
//   clock, clear                     : clock and asynchronous active-low reset
//   res_valid/res_ready              : ALU result handshake
//   res_opcode, res_data             : 5-bit opcode and {hi, lo} result
//   wb_valid/wb_ready                : registered writeback handshake
//   wb_data, wb_opcode               : writeback value and its opcode
//   hi_q, lo_q                       : architectural HI/LO registers
//   count                            : FIFO occupancy
module alu_result_stage #(
    parameter int DEPTH = 2,   // power of two, 2..8
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [4:0]             res_opcode,
    input  logic [2*WIDTH-1:0]     res_data,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [WIDTH-1:0]       wb_data,
    output logic [4:0]             wb_opcode,
    output logic [WIDTH-1:0]       hi_q,
    output logic [WIDTH-1:0]       lo_q,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;

    typedef struct packed {
        logic [4:0]         opcode;
        logic [2*WIDTH-1:0] data;
    } entry_t;

    entry_t in_entry;
    entry_t head_entry;
    logic   push;
    logic   pop;

    // res_ready is a pure function of registered count. There is no
    // pass-through when full, so a combinational path from wb_ready to
    // res_ready cannot form.
    assign res_ready = (count != FULL_CNT);
    assign push      = res_valid && res_ready;

    // Retire when something is queued and the wb register is free or
    // is being emptied this cycle.
    assign pop = (count != '0) && (!wb_valid || wb_ready);

    assign in_entry.opcode = res_opcode;
    assign in_entry.data   = res_data;

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(entry_t))
    ) u_fifo (
        .clock     (clock),
        .clear     (clear),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (count)
    );

    // Retire logic. mfhi/mflo read hi_q/lo_q as registered. A mul/div
    // ahead of them in the queue has retired at an earlier edge, so an
    // mfhi/mflo always sees the newest HI/LO.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_opcode <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (pop) begin
            wb_opcode <= head_entry.opcode;
            case (head_entry.opcode)
                OP_MUL, OP_DIV: begin
                    hi_q     <= head_entry.data[2*WIDTH-1:WIDTH];
                    lo_q     <= head_entry.data[WIDTH-1:0];
                    wb_valid <= 1'b0;
                end
                OP_MFHI: begin
                    wb_data  <= hi_q;
                    wb_valid <= 1'b1;
                end
                OP_MFLO: begin
                    wb_data  <= lo_q;
                    wb_valid <= 1'b1;
                end
                default: begin
                    // Undefined opcodes also take this path. The upper
                    // half of the result is dropped.
                    wb_data  <= head_entry.data[WIDTH-1:0];
                    wb_valid <= 1'b1;
                end
            endcase
        end else if (wb_valid && wb_ready) begin
            // wb_data and wb_opcode keep their last values.
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic                   clock;
    logic                   clear;
    logic                   res_valid;
    logic                   res_ready;
    logic [4:0]             res_opcode;
    logic [2*WIDTH-1:0]     res_data;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [WIDTH-1:0]       wb_data;
    logic [4:0]             wb_opcode;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;
    logic [$clog2(DEPTH):0] count;

    alu_result_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .clear      (clear),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_opcode (res_opcode),
        .res_data   (res_data),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_opcode  (wb_opcode),
        .hi_q       (hi_q),
        .lo_q       (lo_q),
        .count      (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] data;
        bit          exp_wb;
        logic [31:0] exp_val;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[10];

    int          total = 0;
    int          bad   = 0;
    bit          accepted;
    bit          cur_exp_wb;
    logic [31:0] cur_exp_val;
    bit          toggle_rdy;
    bit          hold_pending;
    logic [31:0] prev_data;
    logic [4:0]  prev_op;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sampling at the negedge keeps inputs stable from posedge+1 onward.
    // Everything seen here is what the next posedge acts on.
    task automatic sample();
        exp_t e;
        chk("count_le_depth", 64'(count <= DEPTH), 64'd1);
        if (hold_pending) begin
            chk("hold_valid", wb_valid, 1'b1);
            chk("hold_data", wb_data, prev_data);
            chk("hold_opcode", wb_opcode, prev_op);
        end
        hold_pending = wb_valid && !wb_ready;
        prev_data    = wb_data;
        prev_op      = wb_opcode;
        if (wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got data %h op %b, want no writeback (t=%0t)",
                         wb_data, wb_opcode, $time);
            end else begin
                e = sb.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_opcode", wb_opcode, e.op);
            end
        end
        accepted = res_valid && res_ready;
        if (accepted && cur_exp_wb) begin
            e.op   = res_opcode;
            e.data = cur_exp_val;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        if (toggle_rdy) wb_ready = ~wb_ready;
    endtask

    task automatic push_op(input logic [4:0] op, input logic [63:0] data,
                           input bit exp_wb, input logic [31:0] exp_val);
        res_opcode  = op;
        res_data    = data;
        cur_exp_wb  = exp_wb;
        cur_exp_val = exp_val;
        res_valid   = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (accepted) break;
        end
        res_valid = 1'b0;
        chk("push_accepted", accepted, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((count != 0 || wb_valid) && n < 100) begin
            step();
            n++;
        end
        chk("drain_done", 64'(count == 0 && !wb_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op        data                     wb  value          hi             lo
        vecs[0] = '{5'b01111, 64'h0000_0001_8000_0000, 0, 32'h0,        32'h1,         32'h8000_0000};
        vecs[1] = '{5'b10111, 64'hDEAD_BEEF_DEAD_BEEF, 1, 32'h1,        32'h1,         32'h8000_0000};
        vecs[2] = '{5'b11000, 64'h0123_4567_89AB_CDEF, 1, 32'h8000_0000, 32'h1,        32'h8000_0000};
        vecs[3] = '{5'b00011, 64'hFFFF_FFFF_1234_5678, 1, 32'h1234_5678, 32'h1,        32'h8000_0000};
        vecs[4] = '{5'b10000, 64'h0000_0003_0000_0005, 0, 32'h0,        32'h3,         32'h5};
        vecs[5] = '{5'b01111, 64'hAAAA_AAAA_5555_5555, 0, 32'h0,        32'hAAAA_AAAA, 32'h5555_5555};
        vecs[6] = '{5'b10111, 64'h0,                   1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h5555_5555};
        vecs[7] = '{5'b00000, 64'h0000_0001_0000_0042, 1, 32'h42,       32'hAAAA_AAAA, 32'h5555_5555};
        vecs[8] = '{5'b11000, 64'h0,                   1, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555};
        vecs[9] = '{5'b11111, 64'h7777_7777_0000_0009, 1, 32'h9,        32'hAAAA_AAAA, 32'h5555_5555};

        res_valid    = 1'b0;
        res_opcode   = '0;
        res_data     = '0;
        wb_ready     = 1'b1;
        toggle_rdy   = 1'b0;
        hold_pending = 1'b0;
        cur_exp_wb   = 1'b0;
        cur_exp_val  = '0;
        accepted     = 1'b0;
        prev_data    = '0;
        prev_op      = '0;

        // Reset and idle
        clear = 1'b1;
        #3 clear = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_opcode", wb_opcode, 0);
        #9 clear = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_count", count, 0);
        chk("idle_wb_valid", wb_valid, 0);
        chk("idle_hi", hi_q, 0);
        chk("idle_lo", lo_q, 0);
        chk("idle_res_ready", res_ready, 1);

        // Add passthrough with 2-edge latency
        push_op(5'b00011, 64'h7, 1, 32'h7);
        chk("lat_e1_wb_valid", wb_valid, 0);
        chk("lat_e1_count", count, 1);
        step();
        chk("lat_e2_wb_valid", wb_valid, 1);
        chk("lat_e2_wb_data", wb_data, 32'h7);
        chk("lat_e2_wb_opcode", wb_opcode, 5'b00011);
        chk("lat_hi", hi_q, 0);
        chk("lat_lo", lo_q, 0);
        drain();

        // Table vectors, one at a time with HI/LO checked after each
        for (int i = 0; i < 10; i++) begin
            push_op(vecs[i].op, vecs[i].data, vecs[i].exp_wb, vecs[i].exp_val);
            drain();
            chk("vec_hi", hi_q, vecs[i].exp_hi);
            chk("vec_lo", lo_q, vecs[i].exp_lo);
        end

        // Back-to-back mul, mul, mfhi, mflo streamed without gaps
        push_op(5'b01111, 64'h1111_1111_2222_2222, 0, 32'h0);
        push_op(5'b01111, 64'h3333_3333_4444_4444, 0, 32'h0);
        push_op(5'b10111, 64'h0, 1, 32'h3333_3333);
        push_op(5'b11000, 64'h0, 1, 32'h4444_4444);
        drain();
        chk("b2b_hi", hi_q, 32'h3333_3333);
        chk("b2b_lo", lo_q, 32'h4444_4444);
        chk("b2b_sb_empty", sb.size(), 0);

        // Backpressure until full, then a refused push
        wb_ready = 1'b0;
        push_op(5'b00011, 64'd1, 1, 32'd1);
        push_op(5'b00011, 64'd2, 1, 32'd2);
        push_op(5'b00011, 64'd3, 1, 32'd3);
        chk("full_count", count, 2);
        chk("full_res_ready", res_ready, 0);
        chk("full_wb_valid", wb_valid, 1);
        chk("full_wb_data", wb_data, 32'd1);
        res_opcode  = 5'b00011;
        res_data    = 64'd4;
        cur_exp_wb  = 1'b1;
        cur_exp_val = 32'd4;
        res_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("push4_refused", accepted, 0);
            chk("full_hold_count", count, 2);
            chk("full_hold_data", wb_data, 32'd1);
        end
        res_valid = 1'b0;
        wb_ready  = 1'b1;
        drain();
        chk("bp_sb_empty", sb.size(), 0);

        // Wrap-around with wb_ready toggling every cycle
        toggle_rdy = 1'b1;
        for (int v = 10; v < 20; v++) begin
            push_op(5'b00011, 64'(v), 1, 32'(v));
        end
        toggle_rdy = 1'b0;
        wb_ready   = 1'b1;
        drain();
        chk("wrap_sb_empty", sb.size(), 0);

        // Mid-operation asynchronous reset with the FIFO full
        wb_ready = 1'b0;
        push_op(5'b00011, 64'd5, 1, 32'd5);
        push_op(5'b00011, 64'd6, 1, 32'd6);
        push_op(5'b00011, 64'd7, 1, 32'd7);
        chk("pre_rst_count", count, 2);
        chk("pre_rst_wb_valid", wb_valid, 1);
        clear = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_wb_opcode", wb_opcode, 0);
        chk("arst_hi", hi_q, 0);
        chk("arst_lo", lo_q, 0);
        chk("arst_res_ready", res_ready, 1);
        #2 clear = 1'b1;
        sb.delete();
        hold_pending = 1'b0;
        wb_ready     = 1'b1;
        repeat (6) step();
        chk("post_rst_count", count, 0);
        chk("post_rst_wb_valid", wb_valid, 0);
        push_op(5'b00011, 64'h55, 1, 32'h55);
        drain();
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
